// File: rtl/crc_goback_lane.sv
// crc_goback_lane: queue finished CRC remainders and strip trailing zero-pad bytes by running the CRC backwards
module crc_goback_lane #(
  parameter logic [31:0] POLY = 32'h04C11DB7,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter int STEP_BYTES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_dval,
  input  logic [3:0]  in_packet_num,
  input  logic [11:0] in_zero_num,
  input  logic [31:0] in_dout,
  output logic        out_dval,
  output logic [3:0]  out_packet_num,
  output logic [31:0] out_crc,
  output logic        overflow,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SHIFT, EMIT} state_t;
  state_t state, state_n;
  logic [47:0] fifo [FIFO_DEPTH];
  logic [47:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [31:0] crc_r, crc_n, stepped;
  logic [11:0] rem_r, rem_n, k;
  logic [3:0] tag_r, tag_n;
  logic push, pop, wr_ok;
  logic unused_sop;
  assign unused_sop = in_sop;
  assign head = fifo[rd_ptr];
  assign push = in_dval && in_eop;
  assign pop = (state == IDLE) && (count != '0);
  assign wr_ok = push && ((count != (AW+1)'(FIFO_DEPTH)) || pop);
  assign k = (rem_r < 12'(STEP_BYTES)) ? rem_r : 12'(STEP_BYTES);
  assign busy = (state != IDLE) || (count != '0);
  // Only the first 8*k inverse steps of the unrolled chain take effect on a short final step.
  always_comb begin
    stepped = crc_r;
    for (int i = 0; i < 8*STEP_BYTES; i++)
      if (i < 8*int'(k))
        stepped = stepped[0] ? (((stepped ^ POLY) >> 1) | 32'h80000000) : (stepped >> 1);
  end
  always_comb begin
    state_n = state;
    crc_n = crc_r;
    rem_n = rem_r;
    tag_n = tag_r;
    case (state)
      IDLE: if (pop) begin
        crc_n = head[31:0];
        rem_n = head[43:32];
        tag_n = head[47:44];
        state_n = (head[43:32] != '0) ? SHIFT : EMIT;
      end
      SHIFT: begin
        crc_n = stepped;
        rem_n = rem_r - k;
        state_n = (rem_n == '0) ? EMIT : SHIFT;
      end
      EMIT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst && wr_ok) fifo[wr_ptr] <= {in_packet_num, in_zero_num, in_dout};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      crc_r <= '0;
      rem_r <= '0;
      tag_r <= '0;
      out_dval <= 1'b0;
      out_crc <= '0;
      out_packet_num <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      crc_r <= crc_n;
      rem_r <= rem_n;
      tag_r <= tag_n;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
      overflow <= overflow || (push && !wr_ok);
      out_dval <= (state == EMIT);
      if (state == EMIT) begin
        out_crc <= crc_r ^ XOR_OUT;
        out_packet_num <= tag_r;
      end
    end
  end
endmodule
